// File: rtl/fifo_pkg.sv
// Shared sizing constants for the 8 x 12 transaction-layer FIFO.
package fifo_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned DEPTH  = 1 << PTR_W;
  // Occupancy needs one extra bit so that 0..DEPTH is representable.
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned AF_TH  = 6;
  localparam int unsigned AE_TH  = 2;

endpackage

// File: rtl/fifo_if.sv
// Push/pop handshake and status bundle of the FIFO controller.
//   master : upstream/downstream stages (drive push/pop/data_in, see status)
//   slave  : fifo_ctrl (sees requests, drives read data and status)
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned CW = CNT_W
);

  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;
  logic [CW-1:0] count;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           overflow, underflow, count
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           overflow, underflow, count
  );

endinterface

// File: rtl/fifo_mem.sv
// Dual-port register array: one write and one registered read per cycle.
// A read and write to the same address in one cycle returns the old word.
//   clk    : clock
//   wr_e   : write enable, wr_ptr : write address, data_w : write data
//   rd_e   : read enable,  rd_ptr : read address,  data_r : registered read data
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned PW = PTR_W
) (
  input  logic          clk,
  input  logic          wr_e,
  input  logic [PW-1:0] wr_ptr,
  input  logic [DW-1:0] data_w,
  input  logic          rd_e,
  input  logic [PW-1:0] rd_ptr,
  output logic [DW-1:0] data_r
);

  localparam int unsigned N = 1 << PW;

  logic [DW-1:0] mem_q [N];

  // Storage write; array contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_e) mem_q[wr_ptr] <= data_w;
  end

  // Registered read; holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (rd_e) data_r <= mem_q[rd_ptr];
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointers, occupancy count, status flags and sticky
// overflow/underflow around one fifo_mem instance.
//   clk     : clock, all state on posedge
//   reset_L : asynchronous active-low reset
//   bus     : fifo_if.slave (push/data_in/pop in; data_out/valid_out,
//             full/empty/almost_full/almost_empty, overflow/underflow,
//             count out)
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned PW = PTR_W,
  parameter int unsigned AF = AF_TH,
  parameter int unsigned AE = AE_TH
) (
  input  logic   clk,
  input  logic   reset_L,
  fifo_if.slave  bus
);

  localparam int unsigned CW = PW + 1;
  localparam int unsigned N  = 1 << PW;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_seen_q, rd_seen_d;

  logic          full_c, empty_c;
  logic          push_ok_c, pop_ok_c;
  logic [DW-1:0] mem_rd;

  // Flag decode straight off the count register.
  assign full_c  = (count_q == CW'(N));
  assign empty_c = (count_q == '0);

  // Accept rules, on pre-edge state; a pop frees a slot for a push at full.
  assign pop_ok_c  = bus.pop & ~empty_c;
  assign push_ok_c = bus.push & (~full_c | pop_ok_c);

  // Next-state computation.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    valid_d   = pop_ok_c;
    ovf_d     = ovf_q | (bus.push & ~push_ok_c);
    unf_d     = unf_q | (bus.pop & empty_c);
    rd_seen_d = rd_seen_q | pop_ok_c;

    if (push_ok_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  fifo_mem #(.DW(DW), .PW(PW)) u_mem (
    .clk    (clk),
    .wr_e   (push_ok_c),
    .wr_ptr (wr_ptr_q),
    .data_w (bus.data_in),
    .rd_e   (pop_ok_c),
    .rd_ptr (rd_ptr_q),
    .data_r (mem_rd)
  );

  // The array read register has no reset, so data_out reads as zero until
  // the first accepted pop after reset has reloaded it.
  assign bus.data_out     = rd_seen_q ? mem_rd : '0;
  assign bus.valid_out    = valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= CW'(AF));
  assign bus.almost_empty = (count_q <= CW'(AE));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus random
// push/pop traffic compared against a queue-based model.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic clk;
  logic reset_L;

  fifo_if bus ();

  fifo_ctrl dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [11:0] mq[$];
  logic [11:0] m_dout;
  logic        m_valid;
  logic        m_ovf;
  logic        m_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    chk("count",        32'(bus.count),        32'(sz));
    chk("full",         32'(bus.full),         32'(sz == 8));
    chk("empty",        32'(bus.empty),        32'(sz == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(sz >= 6));
    chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= 2));
    chk("valid_out",    32'(bus.valid_out),    32'(m_valid));
    chk("data_out",     32'(bus.data_out),     32'(m_dout));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("underflow",    32'(bus.underflow),    32'(m_unf));
  endtask

  // One clock: drive request, update model from pre-edge state, check after edge.
  task automatic step(input logic p, input logic [11:0] d, input logic r);
    bit pop_ok, push_ok;
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = r;
    pop_ok  = r && (mq.size() > 0);
    push_ok = p && ((mq.size() < 8) || pop_ok);
    if (p && !push_ok)        m_ovf = 1'b1;
    if (r && mq.size() == 0)  m_unf = 1'b1;
    m_valid = pop_ok;
    if (pop_ok)  m_dout = mq.pop_front();
    if (push_ok) mq.push_back(d);
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    check_all();
  endtask

  initial begin
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    reset_L     = 1'b1;
    model_reset();
    #2 reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk) reset_L = 1'b1;
    @(posedge clk);
    #1;

    // Basic three pushes then three pops
    step(1, 12'h00A, 0);
    step(1, 12'h0AA, 0);
    step(1, 12'hABC, 0);
    step(0, 12'h000, 1); chk("pop1_data", 32'(bus.data_out), 32'h00A);
    step(0, 12'h000, 1); chk("pop2_data", 32'(bus.data_out), 32'h0AA);
    step(0, 12'h000, 1); chk("pop3_data", 32'(bus.data_out), 32'hABC);
    chk("empty_after3", 32'(bus.empty), 32'd1);

    // Fill to full, overflow on the 9th, drain
    for (int i = 1; i <= 8; i++) step(1, 12'(i), 0);
    step(1, 12'hFFF, 0);
    chk("ovf_set",  32'(bus.overflow), 32'd1);
    chk("ovf_cnt8", 32'(bus.count),    32'd8);
    for (int i = 1; i <= 8; i++) step(0, 12'h000, 1);
    chk("last_drained", 32'(bus.data_out), 32'h008);

    // Wrap-around
    for (int i = 0; i < 5; i++) step(1, 12'h050 + 12'(i), 0);
    for (int i = 0; i < 5; i++) step(0, 12'h000, 1);
    for (int i = 0; i < 6; i++) step(1, 12'h100 + 12'(i), 0);
    chk("wrap_af", 32'(bus.almost_full), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 12'h000, 1);
    chk("wrap_last", 32'(bus.data_out), 32'h105);

    // Simultaneous push+pop at full
    for (int i = 0; i < 8; i++) step(1, 12'h200 + 12'(i), 0);
    step(1, 12'h0BB, 1);
    chk("full_pp_data", 32'(bus.data_out), 32'h200);
    chk("full_pp_cnt",  32'(bus.count),    32'd8);
    for (int i = 0; i < 8; i++) step(0, 12'h000, 1);
    chk("full_pp_bb", 32'(bus.data_out), 32'h0BB);

    // Simultaneous push+pop at empty
    step(1, 12'h0CC, 1);
    chk("empty_pp_unf",   32'(bus.underflow), 32'd1);
    chk("empty_pp_valid", 32'(bus.valid_out), 32'd0);
    chk("empty_pp_cnt",   32'(bus.count),     32'd1);
    step(0, 12'h000, 1);
    chk("empty_pp_cc", 32'(bus.data_out), 32'h0CC);

    // Asynchronous reset mid-stream at count 4
    for (int i = 0; i < 4; i++) step(1, 12'h300 + 12'(i), 0);
    step(0, 12'h000, 1);
    step(1, 12'h304, 0);
    #3 reset_L = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk) reset_L = 1'b1;
    @(posedge clk);
    #1;
    step(1, 12'h123, 0);
    step(0, 12'h000, 1);
    chk("post_rst_data", 32'(bus.data_out), 32'h123);

    // Random traffic, alternating bias to visit both full and empty
    for (int i = 0; i < 400; i++) begin
      int unsigned bias;
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < bias, 12'($urandom),
           $urandom_range(0, 99) < (100 - bias));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous 8-entry x 12-bit FIFO controller for transaction-layer buffering between the PCIe TL stages.
- Owns the write and read pointers, the entry count and the status flags. Generates the wr_e/rd_e/wr_ptr/rd_ptr/data_w strobes that drive the dual-port storage array.
- Presents a push/pop interface upstream and downstream, with almost-full/almost-empty flags for flow control (pause) to neighbouring stages.

Parameters:
- DATA_W, 12, data word width.
- PTR_W, 3, pointer width; depth = 2**PTR_W = 8.
- AF_TH, 6, almost_full asserted when count >= AF_TH.
- AE_TH, 2, almost_empty asserted when count <= AE_TH.

Ports:
- clk  input  1  single clock, all state on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- push  input  1  write request, data_in sampled on the same edge.
- data_in  input  DATA_W  write data.
- pop  input  1  read request.
- data_out  output  DATA_W  read data, registered.
- valid_out  output  1  data_out valid; one-cycle pulse per accepted pop.
- full  output  1  count == 8.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_TH.
- almost_empty  output  1  count <= AE_TH.
- overflow  output  1  sticky: push attempted while full and not simultaneously popped.
- underflow  output  1  sticky: pop attempted while empty.
- count  output  PTR_W+1  current occupancy, 0..8.

Behaviour:
- Reset (reset_L low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0.
  - overflow=0, underflow=0.
  - Flags are decoded from count, so empty=1, almost_empty=1, full=0, almost_full=0.
  - Storage contents are not cleared and are irrelevant.
- Reset mid-operation: all in-flight state is discarded immediately. The first accepted push after reset_L rises lands at entry 0.
- Accept rules, evaluated on the state before the edge:
  - push_ok = push & (~full | pop_ok).
  - pop_ok = pop & ~empty.
- Write (push_ok): mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1. Pointers are modulo 8, so 7 wraps to 0.
- Read (pop_ok):
  - data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 (mod 8); valid_out <= 1 on that same edge.
  - Latency: data is visible in the cycle after the pop edge.
  - With no pop_ok, valid_out <= 0 and data_out holds its last value.
- Count update:
  - push_ok only: +1.
  - pop_ok only: -1.
  - Both or neither: unchanged.
- Full with simultaneous push and pop: both accepted, count stays 8, no overflow.
- Empty with simultaneous push and pop: the pop is rejected and underflow is set. The push is accepted, so count becomes 1. There is no read-through bypass.
- Push while full with no pop: the data is dropped, pointers and count are unchanged, overflow is set.
- Pop while empty: valid_out=0, data_out is unchanged, underflow is set.
- overflow and underflow stay set until reset.
- Flags are combinational decodes of the count register, so they are glitch-free relative to clk and never run ahead of count.
- Storage write/read-address timing: one write and one read per cycle to different or equal addresses. When both hit the same address in one cycle, the read returns old data. This case is only reachable when full with simultaneous push and pop, and old data is the correct FIFO data there.
- No combinational path from any input to any output except through the flag decode of registered count.

Decomposition:
- Shared package fifo_pkg:
  - DATA_W and PTR_W defaults.
  - DEPTH = 1<<PTR_W.
  - A count-type width constant.
  - Default AF_TH/AE_TH.
- Sub-module fifo_mem:
  - 8x12 dual-port register array with ports clk, wr_e, wr_ptr, data_w, rd_e, rd_ptr, data_r.
  - Registered read, no reset on the array.
- fifo_ctrl instantiates one fifo_mem and contains only the pointer, count, flag and sticky-error logic.

Test Plan:
- Reset, then push 0x00A, 0x0AA, 0xABC on three consecutive cycles, then pop three times.
  - Required: data_out 0x00A, 0x0AA, 0xABC, each with valid_out=1 exactly one cycle after its pop.
  - Count goes 1,2,3,2,1,0; empty returns to 1.
- Push 8 words 0x001..0x008.
  - Required: almost_full rises after the 6th push and full rises after the 8th.
  - A 9th push of 0xFFF sets overflow, and count stays 8.
  - Popping all 8 returns 0x001..0x008; 0xFFF never appears.
- Wrap-around: push 5, pop 5, push 6 (0x100..0x105), pop 6.
  - Required: data comes out in order across the 7-to-0 pointer wrap.
  - Count peaks at 6 with almost_full=1.
- Simultaneous push+pop at full (count 8), pushing 0x0BB.
  - Required: count stays 8, no overflow, data_out is the oldest word.
  - 0x0BB is returned after the other seven.
- Simultaneous push+pop at empty, pushing 0x0CC.
  - Required: underflow=1, valid_out=0, count=1.
  - The next pop returns 0x0CC.
- Reset asserted asynchronously mid-stream with count=4.
  - Required: immediately count=0, empty=1, valid_out=0, overflow=0, underflow=0.
  - After release, push 0x123 then pop returns 0x123.
